// File: rtl/relm_adc_pkg.sv
// Shared types and constants for the ADC128S022 scan controller.
package relm_adc_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_HOLD} adc_state_t;

  localparam int FRAME_BITS   = 16;
  localparam int ADDR_MSB_BIT = 2;
  localparam int ADDR_LSB_BIT = 4;
  localparam int SAMPLE_W     = 12;

  localparam int FRESH_BIT = 15;
  localparam int BUSY_BIT  = 16;
  localparam int CH_LSB    = 12;

  // DIN value for frame bit k: the 3-bit address goes out MSB first in bits 2..4.
  function automatic logic addr_bit(input logic [3:0] k, input logic [2:0] a);
    case (k)
      4'(ADDR_MSB_BIT):     return a[2];
      4'(ADDR_MSB_BIT + 1): return a[1];
      4'(ADDR_LSB_BIT):     return a[0];
      default:              return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/relm_adc_rr_pick.sv
// Round-robin finder: first enabled channel strictly after 'last', wrapping 7->0.
module relm_adc_rr_pick (
  input  logic [7:0] mask,
  input  logic [2:0] last,
  output logic [2:0] next_ch,
  output logic       none_flag
);
  logic [2:0] idx;

  always_comb begin
    next_ch   = last;
    none_flag = (mask == 8'd0);
    idx       = '0;
    // Walk from farthest (last itself) to nearest so the nearest hit wins.
    for (int i = 8; i >= 1; i--) begin
      idx = last + 3'(i);
      if (mask[idx]) next_ch = idx;
    end
  end
endmodule

// File: rtl/relm_adc_scan.sv
// Autonomous ADC128S022 scanner: round-robin over a channel mask, results in a readable bank.
module relm_adc_scan
  import relm_adc_pkg::*;
#(
  parameter int WD     = 32,
  parameter int CLKDIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] cfg_d,
  output logic        cfg_retry,
  input  logic [WD:0] rd_d,
  output logic [WD:0] rd_q,
  output logic        adc_cs_n_out,
  output logic        adc_saddr_out,
  output logic        adc_sclk_out,
  input  logic        adc_sdat_in
);
  adc_state_t            state;
  logic [7:0]            cnt;
  logic [3:0]            bitn;
  logic [2:0]            addr, prev_addr, pick_ch, rd_sel;
  logic                  prev_valid, none_flag, scan_go, last_cnt, store, rd_stb;
  logic [1:0]            sdat_sync;
  logic [FRAME_BITS-1:0] shift, shift_nxt;
  logic [7:0]            mask, fresh;
  logic                  run;
  logic [SAMPLE_W-1:0]   bank [8];
  logic                  unused;

  assign cfg_retry = 1'b0;
  assign rd_stb    = rd_d[WD];
  assign rd_sel    = rd_d[2:0];
  assign unused    = ^{cfg_d[WD-1:9], rd_d[WD-1:3]};
  assign last_cnt  = (cnt == 8'(CLKDIV - 1));
  assign scan_go   = run & ~none_flag;
  assign shift_nxt = {shift[FRAME_BITS-2:0], sdat_sync[1]};
  // Data clocked in during this frame belongs to the previous frame's address.
  assign store     = (state == ST_HIGH) && last_cnt && (bitn == 4'(FRAME_BITS - 1)) && prev_valid;

  relm_adc_rr_pick u_pick (
    .mask      (mask),
    .last      (addr),
    .next_ch   (pick_ch),
    .none_flag (none_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sdat_sync <= '0;
    else     sdat_sync <= {sdat_sync[0], adc_sdat_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      run  <= 1'b0;
    end else if (cfg_d[WD]) begin
      mask <= cfg_d[7:0];
      run  <= cfg_d[8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bitn          <= '0;
      addr          <= 3'd7;
      prev_addr     <= '0;
      prev_valid    <= 1'b0;
      shift         <= '0;
      adc_cs_n_out  <= 1'b1;
      adc_sclk_out  <= 1'b1;
      adc_saddr_out <= 1'b0;
    end else begin
      if (state != ST_IDLE) cnt <= last_cnt ? 8'd0 : cnt + 8'd1;
      unique case (state)
        ST_IDLE: if (scan_go) begin
          state        <= ST_SETUP;
          addr         <= pick_ch;
          adc_cs_n_out <= 1'b0;
        end
        ST_SETUP: if (last_cnt) begin
          state         <= ST_LOW;
          bitn          <= '0;
          adc_sclk_out  <= 1'b0;
          adc_saddr_out <= addr_bit(4'd0, addr);
        end
        ST_LOW: if (last_cnt) begin
          state        <= ST_HIGH;
          adc_sclk_out <= 1'b1;
        end
        ST_HIGH: if (last_cnt) begin
          shift <= shift_nxt;
          bitn  <= bitn + 4'd1;
          if (bitn == 4'(FRAME_BITS - 1)) begin
            state         <= ST_HOLD;
            adc_cs_n_out  <= 1'b1;
            adc_saddr_out <= 1'b0;
            prev_addr     <= addr;
            prev_valid    <= 1'b1;
          end else begin
            state         <= ST_LOW;
            adc_sclk_out  <= 1'b0;
            adc_saddr_out <= addr_bit(bitn + 4'd1, addr);
          end
        end
        ST_HOLD: if (last_cnt) begin
          if (scan_go) begin
            state        <= ST_SETUP;
            addr         <= pick_ch;
            adc_cs_n_out <= 1'b0;
          end else begin
            state      <= ST_IDLE;
            prev_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Store is ordered after the read-clear so a same-cycle collision leaves fresh set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
      fresh <= '0;
    end else begin
      if (rd_stb) fresh[rd_sel] <= 1'b0;
      if (store) begin
        bank[prev_addr]  <= shift_nxt[SAMPLE_W-1:0];
        fresh[prev_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_q                   = '0;
    rd_q[SAMPLE_W-1:0]     = bank[rd_sel];
    rd_q[CH_LSB +: 3]      = rd_sel;
    rd_q[FRESH_BIT]        = fresh[rd_sel];
    rd_q[BUSY_BIT]         = (state != ST_IDLE);
  end
endmodule

// File: tb/tb_relm_adc_scan.sv
// Randomized bench for relm_adc_scan with an ADC128S022 model and a bank/fresh scoreboard.
module tb_relm_adc_scan;
  localparam int WD     = 32;
  localparam int CLKDIV = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [WD:0] cfg_d, rd_d, rd_q;
  logic        cfg_retry, cs_n, saddr, sclk;
  logic        sdat = 1'b0;

  relm_adc_scan #(.WD(WD), .CLKDIV(CLKDIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_d         (cfg_d),
    .cfg_retry     (cfg_retry),
    .rd_d          (rd_d),
    .rd_q          (rd_q),
    .adc_cs_n_out  (cs_n),
    .adc_saddr_out (saddr),
    .adc_sclk_out  (sclk),
    .adc_sdat_in   (sdat)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] nxt(input logic [7:0] m, input logic [2:0] last);
    for (int i = 1; i <= 8; i++)
      if (m[(int'(last) + i) % 8]) return 3'((int'(last) + i) % 8);
    return last;
  endfunction

  // Scoreboard and ADC model state
  logic [11:0] ch_val [8];
  logic [11:0] m_bank [8];
  logic [7:0]  m_fresh, m_mask;
  logic [2:0]  m_last, exp_addr, din_addr, adc_ch, data_ch, last_sent;
  logic [11:0] frame_data;
  logic        cs_prev = 1'b1, sclk_prev = 1'b1;
  bit          had_frame, frame_cont;
  int          cyc = 0, rise_cyc, fall_cyc, nfall, nrise;
  int          n_frames = 0, n_starts = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      had_frame = 0; frame_cont = 0; m_mask = '0; m_last = 3'd7; adc_ch = '0;
      m_fresh = '0; sdat = 1'b0; last_sent = '0;
      for (int i = 0; i < 8; i++) m_bank[i] = '0;
    end else begin
      if (rd_d[WD]) m_fresh[rd_d[2:0]] = 1'b0;
      if (cs_prev && !cs_n) begin
        frame_cont = had_frame && (cyc - rise_cyc == CLKDIV);
        if (frame_cont) chk("frame_period", cyc - fall_cyc, 34 * CLKDIV);
        fall_cyc = cyc; nfall = 0; nrise = 0; din_addr = '0;
        exp_addr = nxt(m_mask, m_last);
        m_last = exp_addr;
        data_ch = adc_ch;
        frame_data = ch_val[adc_ch];
        sdat = 1'b0;
        n_starts++;
      end else if (!cs_prev && cs_n) begin
        chk("addr", din_addr, exp_addr);
        chk("sclk_rises", nrise, 16);
        if (frame_cont) begin
          m_bank[data_ch]  = frame_data;
          m_fresh[data_ch] = 1'b1;
        end
        adc_ch = din_addr; last_sent = din_addr;
        had_frame = 1; rise_cyc = cyc; sdat = 1'b0;
        n_frames++;
      end else if (!cs_n) begin
        if (sclk_prev && !sclk) begin
          sdat = (nfall < 4) ? 1'b0 : frame_data[15 - nfall];
          nfall++;
        end
        if (!sclk_prev && sclk) begin
          if (nrise >= 2 && nrise <= 4) din_addr[4 - nrise] = saddr;
          nrise++;
        end
      end
      if (cfg_d[WD]) m_mask = cfg_d[7:0];
    end
    cs_prev = cs_n; sclk_prev = sclk;
  end

  task automatic cfg(input logic [7:0] m, input logic r);
    @(negedge clk);
    cfg_d = '0; cfg_d[WD] = 1'b1; cfg_d[8] = r; cfg_d[7:0] = m;
    @(negedge clk);
    cfg_d = '0;
  endtask

  task automatic rd(input logic [2:0] ch, input logic stb, output logic [WD:0] q);
    @(negedge clk);
    rd_d = '0; rd_d[WD] = stb; rd_d[2:0] = ch;
    #1;
    q = rd_q;
    chk("rd_data", rd_q[11:0], m_bank[ch]);
    chk("rd_fresh", rd_q[15], m_fresh[ch]);
    chk("rd_ch", rd_q[14:12], ch);
    chk("rd_hi_zero", rd_q[WD:17], 0);
    @(negedge clk);
    rd_d = '0;
  endtask

  task automatic wait_frames(input int n);
    int tgt, t;
    tgt = n_frames + n; t = 0;
    while (n_frames < tgt && t < n * 400) begin @(negedge clk); t++; end
    if (n_frames < tgt) chk("timeout_frames", n_frames, tgt);
  endtask

  task automatic wait_start();
    int tgt, t;
    tgt = n_starts + 1; t = 0;
    while (n_starts < tgt && t < 400) begin @(negedge clk); t++; end
    if (n_starts < tgt) chk("timeout_start", n_starts, tgt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [WD:0] q;
    int s0;
    rst = 1'b1; cfg_d = '0; rd_d = '0;
    for (int i = 0; i < 8; i++) ch_val[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_saddr", saddr, 0);
    chk("rst_busy", rd_q[16], 0);
    chk("cfg_retry", cfg_retry, 0);
    @(negedge clk); rst = 1'b0;
    rd(3'd3, 1'b0, q);

    // Two-channel scan: 2 and 5 alternate
    ch_val[2] = 12'h123; ch_val[5] = 12'hA5C;
    cfg(8'h24, 1'b1);
    wait_frames(3);
    chk("seq_third_addr", last_sent, 3'd2);
    rd(3'd2, 1'b1, q);
    chk("ch2_val", q[11:0], 12'h123);
    chk("ch2_fresh", q[15], 1);
    rd(3'd5, 1'b1, q);
    chk("ch5_val", q[11:0], 12'hA5C);
    rd(3'd2, 1'b1, q);
    chk("ch2_refresh", q[15], 0);

    // Randomized masks and reads
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) ch_val[i] = 12'($urandom);
      cfg(8'($urandom_range(1, 255)), 1'b1);
      wait_frames($urandom_range(1, 3));
      repeat (3) rd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), q);
    end

    // Stop mid-frame: frame completes, then idle
    cfg(8'hFF, 1'b1);
    wait_start();
    #1 chk("busy_in_frame", rd_q[16], 1);
    repeat (20) @(negedge clk);
    cfg(8'hFF, 1'b0);
    wait_frames(1);
    repeat (CLKDIV + 2) @(negedge clk);
    #1;
    chk("stop_busy", rd_q[16], 0);
    chk("stop_cs_n", cs_n, 1);
    s0 = n_starts;
    repeat (300) @(negedge clk);
    chk("stop_no_start", n_starts, s0);
    for (int c = 0; c < 8; c++) rd(3'(c), 1'b0, q);

    // Empty mask with run set stays idle; then channel 7 only
    cfg(8'h00, 1'b1);
    repeat (300) @(negedge clk);
    #1;
    chk("empty_busy", rd_q[16], 0);
    chk("empty_no_start", n_starts, s0);
    cfg(8'h80, 1'b1);
    wait_frames(4);
    chk("ch7_repeat", last_sent, 3'd7);
    rd(3'd7, 1'b1, q);

    // Store and read strobe to channel 4 on the same edge
    ch_val[4] = 12'h3C1;
    cfg(8'h10, 1'b1);
    wait_frames(3);
    ch_val[4] = 12'h95E;
    wait_start();
    repeat (33 * CLKDIV - 1) @(negedge clk);
    rd_d = '0; rd_d[WD] = 1'b1; rd_d[2:0] = 3'd4;
    #1 chk("coll_old_data", rd_q[11:0], 12'h3C1);
    @(negedge clk);
    rd_d = '0; rd_d[2:0] = 3'd4;
    #1;
    chk("coll_fresh", rd_q[15], 1);
    chk("coll_new_data", rd_q[11:0], 12'h95E);
    rd(3'd4, 1'b0, q);

    // Reset during LOW of bit 7
    wait_start();
    repeat (CLKDIV + 14 * CLKDIV + 1) @(negedge clk);
    #1 chk("pre_rst_sclk_low", sclk, 0);
    rst = 1'b1;
    rd_d = '0; rd_d[2:0] = 3'd3;
    #1;
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_sclk", sclk, 1);
    chk("mid_rst_saddr", saddr, 0);
    chk("mid_rst_ch3", rd_q[11:0], 0);
    chk("mid_rst_fresh3", rd_q[15], 0);
    chk("mid_rst_busy", rd_q[16], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(3'd4, 1'b0, q);
    chk("post_rst_ch4", q[11:0], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/relm_adc_scan.md
Name: relm_adc_scan

Overview:
Autonomous scan controller for the DE0-Nano ADC128S022 serial ADC. It drives CS_N, SCLK and DIN and samples DOUT, so the CPU no longer bit-bangs the converter through a pop port. It cycles round-robin over a programmable channel mask and stores one 12-bit result per channel in a result bank. The CPU configures it through one push port and reads results through one pop port, both using the standard WD+1 port format (bit WD = strobe).

Parameters:
WD, 32, data width of push/pop ports (port vectors are WD+1 bits)
CLKDIV, 8, clk cycles per SCLK half-period; legal range 3..255; 8 gives 3.125 MHz SCLK at 50 MHz clk

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cfg_d  in  WD+1  push port; [WD] write strobe, [7:0] channel enable mask, [8] run
cfg_retry  out  1  push retry; constant 0
rd_d  in  WD+1  pop port; [WD] read strobe, [2:0] channel select
rd_q  out  WD+1  pop data; [11:0] sample, [14:12] channel, [15] fresh, [16] busy, all other bits including [WD] = 0
adc_cs_n_out  out  1  ADC chip select, active low
adc_saddr_out  out  1  ADC DIN (address)
adc_sclk_out  out  1  ADC SCLK, idles high
adc_sdat_in  in  1  ADC DOUT, asynchronous to clk

Behaviour:
- Reset values: adc_cs_n_out=1, adc_sclk_out=1, adc_saddr_out=0, mask=0, run=0, bank entries=0, fresh flags=0, state=IDLE, prev_valid=0. Reset asserted mid-frame aborts the frame immediately with no store.
- adc_sdat_in passes through a 2-FF synchronizer before use.
- Config write: on cfg_d[WD], mask and run update in the same cycle. A frame in progress always completes with its addressed channel. The new mask is used only for the next channel pick.
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD.
  - IDLE: enter SETUP if run=1 and mask!=0; pick the channel.
  - SETUP: cs_n=0, sclk=1 for CLKDIV cycles.
  - LOW: sclk=0 for CLKDIV cycles. saddr is driven at LOW entry: bit k=2,3,4 (0-based frame bit) carries addr[4-k] (MSB first); all other bits drive 0.
  - HIGH: sclk=1 for CLKDIV cycles. The synchronized DOUT is sampled on the last cycle of HIGH into a 16-bit shift register (MSB first). Bit counter increments leaving HIGH. After bit 15 go to HOLD, otherwise go to LOW.
  - HOLD: cs_n=1, sclk=1 for CLKDIV cycles. Then go to SETUP if run=1 and mask!=0, otherwise IDLE.
- Frame length: exactly 2*CLKDIV*17 clk cycles, SETUP through HOLD.
- Pipelining: the data in frame N belongs to the address sent in frame N-1.
  - On entering HOLD: if prev_valid, store shift[11:0] to bank[prev_addr] and set fresh[prev_addr].
  - Then prev_addr=addr and prev_valid=1.
  - prev_valid clears on entering IDLE. The first frame after IDLE stores nothing.
  - When run is cleared, the last addressed channel's result is lost. This is accepted.
- Channel pick: the next enabled channel strictly after the last addressed channel, wrapping 7->0. If only one bit is set, the same channel repeats. The first pick after reset searches from channel 0.
- rd_q is a combinational read of bank[rd_d[2:0]] and fresh[rd_d[2:0]]. busy = (state!=IDLE).
- A read strobe clears fresh[rd_d[2:0]] at the clock edge.
- A store and a read strobe to the same channel in the same cycle: rd_q returns the old data, and fresh ends up 1 (store wins).

Decomposition:
- Package relm_adc_pkg holds:
  - state enum
  - FRAME_BITS=16, ADDR_MSB_BIT=2, ADDR_LSB_BIT=4, SAMPLE_W=12
  - rd_q field offsets: FRESH_BIT=15, BUSY_BIT=16, CH_LSB=12
- Sub-module relm_adc_rr_pick: combinational next-enabled-channel finder. Inputs are the mask and last channel; outputs are the next channel and none_flag.

Test Plan:
- Reset mid-frame (assert rst during LOW of bit 7) -> all three ADC outputs return to 1/1/0 within the same cycle; rd_q for channel 3 reads 0 with fresh=0.
- ADC model returns 12'hA5C for channel 5 and 12'h123 for channel 2; write mask=8'h24, run=1 -> address sequence on DIN is 2,5,2,5…; after the third HOLD, reading channel 2 gives 12'h123 with fresh=1 and channel 5 gives 12'hA5C; a repeat read of channel 2 gives fresh=0.
- CLKDIV=3 with mask=8'h01 -> each frame measures exactly 102 clk cycles from cs_n fall to the next cs_n fall; samples are correct with the 2-FF sync latency.
- Write run=0 mid-frame -> the frame completes, its store (if prev_valid) happens, busy drops after HOLD, and cs_n stays 1.
- mask=0 with run=1 -> stays IDLE and busy=0. Then mask=8'h80 -> frames start, and channel 7 repeats.
- Force a store to channel 4 in the same cycle as a read strobe of channel 4 -> rd_q shows the previous sample; afterwards fresh[4]=1 and the bank holds the new sample.
